// File: rtl/hazard_stall_ctrl.sv
// Hazard controller for the 5-stage pipeline. It drives the per-register stall/bubble
// controls and the PC hold/redirect, and counts the cycles in which the PC is held.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_RUN     | normal flow; a new memory access in MEM stalls this cycle
// ST_MEMWAIT | multi-cycle access in flight, wait_q counts remaining stall cycles
// ST_MEMDONE | data returns; the access advances and the pipeline is released
module hazard_stall_ctrl #(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [4:0]       i_IFID_RS,
    input  logic [4:0]       i_IFID_RT,
    input  logic             i_IFID_UsesRT,
    input  logic             i_IDEX_MemRead,
    input  logic [4:0]       i_IDEX_RegAddrW,
    input  logic             i_EXMEM_Branch,
    input  logic             i_EXMEM_Zero,
    input  logic             i_EXMEM_MemRead,
    input  logic             i_EXMEM_MemWrite,
    output logic             o_PC_stall,
    output logic             o_PC_sel_branch,
    output logic             o_IFID_stall,
    output logic             o_IFID_bubble,
    output logic             o_IDEX_stall,
    output logic             o_IDEX_bubble,
    output logic             o_EXMEM_stall,
    output logic             o_EXMEM_bubble,
    output logic             o_MEMWB_stall,
    output logic             o_MEMWB_bubble,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_MEMDONE = 2'd2
    } state_t;

    // The wait counter only has to hold MEM_LAT-1, the first stall cycle is spent in ST_RUN.
    localparam int                WAIT_W    = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'((MEM_LAT > 1) ? (MEM_LAT - 1) : 0);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic              MEM_EN    = (MEM_LAT != 0);
    localparam logic              MULTI_CYC = (MEM_LAT > 1);

    state_t            state_q;
    state_t            state_d;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;
    logic [CNT_W-1:0]  stall_cnt_q;

    logic memreq;
    logic memstall;
    logic taken;
    logic loaduse;
    logic rs_match;
    logic rt_match;

    assign memreq   = (i_EXMEM_MemRead | i_EXMEM_MemWrite) & MEM_EN;
    assign memstall = ((state_q == ST_RUN) & memreq) | (state_q == ST_MEMWAIT);
    assign taken    = i_EXMEM_Branch & i_EXMEM_Zero;

    // $zero is never a real producer, so a load targeting it cannot create a hazard.
    assign rs_match = (i_IDEX_RegAddrW == i_IFID_RS);
    assign rt_match = i_IFID_UsesRT & (i_IDEX_RegAddrW == i_IFID_RT);
    assign loaduse  = i_IDEX_MemRead & (i_IDEX_RegAddrW != 5'd0) & (rs_match | rt_match);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            ST_RUN: begin
                if (memreq) begin
                    if (MULTI_CYC) begin
                        state_d = ST_MEMWAIT;
                        wait_d  = WAIT_INIT;
                    end else begin
                        state_d = ST_MEMDONE;
                    end
                end
            end
            ST_MEMWAIT: begin
                wait_d = wait_q - WAIT_ONE;
                if (wait_q <= WAIT_ONE) begin
                    state_d = ST_MEMDONE;
                    wait_d  = '0;
                end
            end
            ST_MEMDONE: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
                wait_d  = '0;
            end
        endcase
    end

    // Outputs are forced low while reset is held so an abandoned access releases at once.
    always_comb begin
        o_PC_stall      = 1'b0;
        o_PC_sel_branch = 1'b0;
        o_IFID_stall    = 1'b0;
        o_IFID_bubble   = 1'b0;
        o_IDEX_stall    = 1'b0;
        o_IDEX_bubble   = 1'b0;
        o_EXMEM_stall   = 1'b0;
        o_EXMEM_bubble  = 1'b0;
        o_MEMWB_stall   = 1'b0;
        o_MEMWB_bubble  = 1'b0;
        if (!nrst) begin
            o_PC_stall = 1'b0;
        end else if (memstall) begin
            o_PC_stall     = 1'b1;
            o_IFID_stall   = 1'b1;
            o_IDEX_stall   = 1'b1;
            o_EXMEM_stall  = 1'b1;
            o_MEMWB_bubble = 1'b1;
        end else if (taken) begin
            o_PC_sel_branch = 1'b1;
            o_IFID_bubble   = 1'b1;
            o_IDEX_bubble   = 1'b1;
            o_EXMEM_bubble  = 1'b1;
        end else if (loaduse) begin
            o_PC_stall    = 1'b1;
            o_IFID_stall  = 1'b1;
            o_IDEX_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stall_cnt_q <= '0;
        end else if (o_PC_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign o_state     = state_q;
    assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: three instances (MEM_LAT 3/0/2) share one stimulus set.
module tb_hazard_stall_ctrl;

    // {PC_stall, PC_sel_branch, IFID s/b, IDEX s/b, EXMEM s/b, MEMWB s/b}
    localparam logic [9:0] O_NONE  = 10'b00_00_00_00_00;
    localparam logic [9:0] O_MEMST = 10'b10_10_10_10_01;
    localparam logic [9:0] O_BR    = 10'b01_01_01_01_00;
    localparam logic [9:0] O_LU    = 10'b10_10_01_00_00;

    logic       clk;
    logic       nrst;
    logic [4:0] rs, rt, idex_rd;
    logic       uses_rt, idex_memread, br, zero, mem_rd, mem_wr;

    logic [9:0]  out_a, out_b, out_c;
    logic [1:0]  st_a, st_b, st_c;
    logic [3:0]  cnt_a, cnt_b;
    logic [31:0] cnt_c;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MEM_LAT(3), .CNT_W(4)) u_dut_a (
        .clk(clk), .nrst(nrst),
        .i_IFID_RS(rs), .i_IFID_RT(rt), .i_IFID_UsesRT(uses_rt),
        .i_IDEX_MemRead(idex_memread), .i_IDEX_RegAddrW(idex_rd),
        .i_EXMEM_Branch(br), .i_EXMEM_Zero(zero),
        .i_EXMEM_MemRead(mem_rd), .i_EXMEM_MemWrite(mem_wr),
        .o_PC_stall(out_a[9]), .o_PC_sel_branch(out_a[8]),
        .o_IFID_stall(out_a[7]), .o_IFID_bubble(out_a[6]),
        .o_IDEX_stall(out_a[5]), .o_IDEX_bubble(out_a[4]),
        .o_EXMEM_stall(out_a[3]), .o_EXMEM_bubble(out_a[2]),
        .o_MEMWB_stall(out_a[1]), .o_MEMWB_bubble(out_a[0]),
        .o_state(st_a), .o_stall_cnt(cnt_a)
    );

    hazard_stall_ctrl #(.MEM_LAT(0), .CNT_W(4)) u_dut_b (
        .clk(clk), .nrst(nrst),
        .i_IFID_RS(rs), .i_IFID_RT(rt), .i_IFID_UsesRT(uses_rt),
        .i_IDEX_MemRead(idex_memread), .i_IDEX_RegAddrW(idex_rd),
        .i_EXMEM_Branch(br), .i_EXMEM_Zero(zero),
        .i_EXMEM_MemRead(mem_rd), .i_EXMEM_MemWrite(mem_wr),
        .o_PC_stall(out_b[9]), .o_PC_sel_branch(out_b[8]),
        .o_IFID_stall(out_b[7]), .o_IFID_bubble(out_b[6]),
        .o_IDEX_stall(out_b[5]), .o_IDEX_bubble(out_b[4]),
        .o_EXMEM_stall(out_b[3]), .o_EXMEM_bubble(out_b[2]),
        .o_MEMWB_stall(out_b[1]), .o_MEMWB_bubble(out_b[0]),
        .o_state(st_b), .o_stall_cnt(cnt_b)
    );

    hazard_stall_ctrl u_dut_c (
        .clk(clk), .nrst(nrst),
        .i_IFID_RS(rs), .i_IFID_RT(rt), .i_IFID_UsesRT(uses_rt),
        .i_IDEX_MemRead(idex_memread), .i_IDEX_RegAddrW(idex_rd),
        .i_EXMEM_Branch(br), .i_EXMEM_Zero(zero),
        .i_EXMEM_MemRead(mem_rd), .i_EXMEM_MemWrite(mem_wr),
        .o_PC_stall(out_c[9]), .o_PC_sel_branch(out_c[8]),
        .o_IFID_stall(out_c[7]), .o_IFID_bubble(out_c[6]),
        .o_IDEX_stall(out_c[5]), .o_IDEX_bubble(out_c[4]),
        .o_EXMEM_stall(out_c[3]), .o_EXMEM_bubble(out_c[2]),
        .o_MEMWB_stall(out_c[1]), .o_MEMWB_bubble(out_c[0]),
        .o_state(st_c), .o_stall_cnt(cnt_c)
    );

    task automatic clear_inputs;
        rs = 5'd0; rt = 5'd0; uses_rt = 1'b0; idex_memread = 1'b0; idex_rd = 5'd0;
        br = 1'b0; zero = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    endtask

    task automatic reset_dut;
        @(negedge clk);
        nrst = 1'b0;
        clear_inputs();
        @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic test_reset;
        // hazards of every kind presented while reset is held
        br = 1'b1; zero = 1'b1; mem_rd = 1'b1;
        idex_memread = 1'b1; idex_rd = 5'd8; rs = 5'd8;
        #3;
        checks++; if (out_a !== O_NONE) begin errors++; $display("FAIL reset_out_a: got %b want %b", out_a, O_NONE); end
        checks++; if (out_c !== O_NONE) begin errors++; $display("FAIL reset_out_c: got %b want %b", out_c, O_NONE); end
        @(negedge clk); #1;
        checks++; if (st_a !== 2'd0) begin errors++; $display("FAIL reset_state_a: got %0d want 0", st_a); end
        checks++; if (cnt_a !== 4'd0) begin errors++; $display("FAIL reset_cnt_a: got %0d want 0", cnt_a); end
        checks++; if (cnt_c !== 32'd0) begin errors++; $display("FAIL reset_cnt_c: got %0d want 0", cnt_c); end
        clear_inputs();
        nrst = 1'b1;
        #1;
        checks++; if (out_a !== O_NONE) begin errors++; $display("FAIL reset_idle_out: got %b want %b", out_a, O_NONE); end
    endtask

    task automatic test_load_use;
        @(negedge clk); idex_memread = 1'b1; idex_rd = 5'd8; rs = 5'd8; #1;
        checks++; if (out_a !== O_LU) begin errors++; $display("FAIL lu_rs_a: got %b want %b", out_a, O_LU); end
        checks++; if (out_c !== O_LU) begin errors++; $display("FAIL lu_rs_c: got %b want %b", out_c, O_LU); end
        @(negedge clk); idex_rd = 5'd0; rs = 5'd0; #1;
        checks++; if (out_a !== O_NONE) begin errors++; $display("FAIL lu_zero_reg: got %b want %b", out_a, O_NONE); end
        @(negedge clk); idex_rd = 5'd9; rs = 5'd1; rt = 5'd9; uses_rt = 1'b1; #1;
        checks++; if (out_a !== O_LU) begin errors++; $display("FAIL lu_rt: got %b want %b", out_a, O_LU); end
        @(negedge clk); uses_rt = 1'b0; #1;
        checks++; if (out_a !== O_NONE) begin errors++; $display("FAIL lu_rt_unused: got %b want %b", out_a, O_NONE); end
        @(negedge clk); idex_memread = 1'b0; idex_rd = 5'd8; rs = 5'd8; #1;
        checks++; if (out_a !== O_NONE) begin errors++; $display("FAIL lu_not_load: got %b want %b", out_a, O_NONE); end
        checks++; if (cnt_a !== 4'd2) begin errors++; $display("FAIL lu_cnt_a: got %0d want 2", cnt_a); end
        checks++; if (cnt_c !== 32'd2) begin errors++; $display("FAIL lu_cnt_c: got %0d want 2", cnt_c); end
        clear_inputs();
    endtask

    task automatic test_branch;
        @(negedge clk); br = 1'b1; zero = 1'b1; #1;
        checks++; if (out_a !== O_BR) begin errors++; $display("FAIL br_taken_a: got %b want %b", out_a, O_BR); end
        checks++; if (out_b !== O_BR) begin errors++; $display("FAIL br_taken_b: got %b want %b", out_b, O_BR); end
        @(negedge clk); zero = 1'b0; #1;
        checks++; if (out_a !== O_NONE) begin errors++; $display("FAIL br_not_taken: got %b want %b", out_a, O_NONE); end
        @(negedge clk); br = 1'b0; zero = 1'b1; #1;
        checks++; if (out_a !== O_NONE) begin errors++; $display("FAIL br_zero_only: got %b want %b", out_a, O_NONE); end
        checks++; if (cnt_a !== 4'd2) begin errors++; $display("FAIL br_cnt_a: got %0d want 2", cnt_a); end
        clear_inputs();
    endtask

    task automatic test_priority;
        @(negedge clk); br = 1'b1; zero = 1'b1; idex_memread = 1'b1; idex_rd = 5'd8; rs = 5'd8; #1;
        checks++; if (out_a !== O_BR) begin errors++; $display("FAIL prio_br_over_lu: got %b want %b", out_a, O_BR); end
        @(negedge clk); mem_wr = 1'b1; #1;
        checks++; if (out_a !== O_MEMST) begin errors++; $display("FAIL prio_mem_over_br_a: got %b want %b", out_a, O_MEMST); end
        checks++; if (out_c !== O_MEMST) begin errors++; $display("FAIL prio_mem_over_br_c: got %b want %b", out_c, O_MEMST); end
        checks++; if (out_b !== O_BR) begin errors++; $display("FAIL prio_lat0_branch: got %b want %b", out_b, O_BR); end
        reset_dut();
    endtask

    task automatic test_mem_wait;
        logic [1:0] es_a [5] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd0};
        logic [9:0] eo_a [5] = '{O_MEMST, O_MEMST, O_MEMST, O_NONE, O_NONE};
        logic [1:0] es_c [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0};
        logic [9:0] eo_c [5] = '{O_MEMST, O_MEMST, O_NONE, O_NONE, O_NONE};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); mem_rd = (k < 3); #1;
            checks++; if (st_a !== es_a[k]) begin errors++; $display("FAIL mem_state_a[%0d]: got %0d want %0d", k, st_a, es_a[k]); end
            checks++; if (out_a !== eo_a[k]) begin errors++; $display("FAIL mem_out_a[%0d]: got %b want %b", k, out_a, eo_a[k]); end
            checks++; if (st_c !== es_c[k]) begin errors++; $display("FAIL mem_state_c[%0d]: got %0d want %0d", k, st_c, es_c[k]); end
            checks++; if (out_c !== eo_c[k]) begin errors++; $display("FAIL mem_out_c[%0d]: got %b want %b", k, out_c, eo_c[k]); end
        end
        @(negedge clk); #1;
        checks++; if (cnt_a !== 4'd3) begin errors++; $display("FAIL mem_cnt_a: got %0d want 3", cnt_a); end
        checks++; if (cnt_c !== 32'd2) begin errors++; $display("FAIL mem_cnt_c: got %0d want 2", cnt_c); end
        checks++; if (cnt_b !== 4'd0) begin errors++; $display("FAIL mem_cnt_b: got %0d want 0", cnt_b); end
        clear_inputs();
    endtask

    task automatic test_back_to_back;
        logic [1:0] es [6] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd0, 2'd1};
        logic [9:0] eo [6] = '{O_MEMST, O_MEMST, O_MEMST, O_NONE, O_MEMST, O_MEMST};
        reset_dut();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); mem_rd = 1'b1; #1;
            checks++; if (st_a !== es[k]) begin errors++; $display("FAIL b2b_state[%0d]: got %0d want %0d", k, st_a, es[k]); end
            checks++; if (out_a !== eo[k]) begin errors++; $display("FAIL b2b_out[%0d]: got %b want %b", k, out_a, eo[k]); end
        end
        @(negedge clk); #1;
        checks++; if (cnt_a !== 4'd5) begin errors++; $display("FAIL b2b_cnt: got %0d want 5", cnt_a); end
        reset_dut();
    endtask

    task automatic test_reset_midwait;
        @(negedge clk); mem_rd = 1'b1; br = 1'b1; zero = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        checks++; if (st_a !== 2'd1) begin errors++; $display("FAIL midwait_state: got %0d want 1", st_a); end
        checks++; if (out_a !== O_MEMST) begin errors++; $display("FAIL midwait_out: got %b want %b", out_a, O_MEMST); end
        nrst = 1'b0; #1;
        checks++; if (out_a !== O_NONE) begin errors++; $display("FAIL midwait_rst_out: got %b want %b", out_a, O_NONE); end
        checks++; if (st_a !== 2'd0) begin errors++; $display("FAIL midwait_rst_state: got %0d want 0", st_a); end
        checks++; if (cnt_a !== 4'd0) begin errors++; $display("FAIL midwait_rst_cnt: got %0d want 0", cnt_a); end
        @(negedge clk); nrst = 1'b1; clear_inputs();
        @(negedge clk); #1;
        checks++; if (st_a !== 2'd0) begin errors++; $display("FAIL midwait_rel_state: got %0d want 0", st_a); end
        checks++; if (cnt_a !== 4'd0) begin errors++; $display("FAIL midwait_rel_cnt: got %0d want 0", cnt_a); end
        checks++; if (out_a !== O_NONE) begin errors++; $display("FAIL midwait_rel_out: got %b want %b", out_a, O_NONE); end
    endtask

    task automatic test_saturate;
        reset_dut();
        @(negedge clk); idex_memread = 1'b1; idex_rd = 5'd4; rs = 5'd4;
        repeat (20) @(negedge clk);
        #1;
        checks++; if (out_a !== O_LU) begin errors++; $display("FAIL sat_out: got %b want %b", out_a, O_LU); end
        checks++; if (cnt_a !== 4'd15) begin errors++; $display("FAIL sat_cnt_a: got %0d want 15", cnt_a); end
        checks++; if (cnt_b !== 4'd15) begin errors++; $display("FAIL sat_cnt_b: got %0d want 15", cnt_b); end
        checks++; if (cnt_c !== 32'd20) begin errors++; $display("FAIL sat_cnt_c: got %0d want 20", cnt_c); end
        clear_inputs();
    endtask

    task automatic test_mem_lat0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); mem_wr = 1'b1; #1;
            checks++; if (out_b !== O_NONE) begin errors++; $display("FAIL lat0_out[%0d]: got %b want %b", k, out_b, O_NONE); end
            checks++; if (st_b !== 2'd0) begin errors++; $display("FAIL lat0_state[%0d]: got %0d want 0", k, st_b); end
        end
        checks++; if (out_a !== O_MEMST) begin errors++; $display("FAIL lat3_still_stalls: got %b want %b", out_a, O_MEMST); end
        clear_inputs();
        reset_dut();
    endtask

    initial begin
        nrst = 1'b0;
        clear_inputs();
        test_reset();
        test_load_use();
        test_branch();
        test_priority();
        test_mem_wait();
        test_back_to_back();
        test_reset_midwait();
        test_saturate();
        test_mem_lat0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
